// File: rtl/jtdd_gfx_arb_if.sv
// jtdd_gfx_arb_if: client and SDRAM read-slot bundle for the gfx ROM arbiter.
// slave = arbiter side, master = layer engines plus SDRAM controller side.
interface jtdd_gfx_arb_if;
  logic        obj_cs;
  logic [17:0] obj_addr;
  logic [15:0] obj_data;
  logic        obj_ok;

  logic        scr_cs;
  logic [16:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ok;

  logic        chr_cs;
  logic [14:0] chr_addr;
  logic [15:0] chr_data;
  logic        chr_ok;

  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [15:0] sdram_data;

  modport slave (
    input  obj_cs, obj_addr,
    input  scr_cs, scr_addr,
    input  chr_cs, chr_addr,
    input  sdram_ack, sdram_rdy, sdram_data,
    output obj_data, obj_ok,
    output scr_data, scr_ok,
    output chr_data, chr_ok,
    output sdram_req, sdram_addr
  );

  modport master (
    output obj_cs, obj_addr,
    output scr_cs, scr_addr,
    output chr_cs, chr_addr,
    output sdram_ack, sdram_rdy, sdram_data,
    input  obj_data, obj_ok,
    input  scr_data, scr_ok,
    input  chr_data, chr_ok,
    input  sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtdd_gfx_arb.sv
// jtdd_gfx_arb: shares one SDRAM read port between obj/scr/chr fetchers.
// Ports: clk, rst (async high), bus (slave: clients + SDRAM read slot).
module jtdd_gfx_arb #(
  parameter logic [21:0] OBJ_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET = 22'h40000,
  parameter logic [21:0] CHR_OFFSET = 22'h60000
) (
  input  logic          clk,
  input  logic          rst,
  jtdd_gfx_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_t;

  typedef enum logic [1:0] {
    C_OBJ,
    C_SCR,
    C_CHR
  } client_t;

  state_t      state, state_nx;
  client_t     sel, sel_nx;
  client_t     last, last_nx;
  client_t     gnt;
  logic        req, req_nx;
  logic [21:0] req_addr, req_addr_nx;
  logic [17:0] req_tag, req_tag_nx;
  logic        fill;

  logic [17:0] obj_tag;
  logic [16:0] scr_tag;
  logic [14:0] chr_tag;
  logic [15:0] obj_dat, scr_dat, chr_dat;
  logic        obj_vld, scr_vld, chr_vld;

  logic        obj_hit, scr_hit, chr_hit;
  logic        busy;
  logic [2:0]  pend;
  logic        gnt_any;
  logic [21:0] obj_full, scr_full, chr_full;

  assign obj_hit = obj_vld & (bus.obj_addr == obj_tag);
  assign scr_hit = scr_vld & (bus.scr_addr == scr_tag);
  assign chr_hit = chr_vld & (bus.chr_addr == chr_tag);

  assign bus.obj_ok   = bus.obj_cs & obj_hit;
  assign bus.scr_ok   = bus.scr_cs & scr_hit;
  assign bus.chr_ok   = bus.chr_cs & chr_hit;
  assign bus.obj_data = obj_dat;
  assign bus.scr_data = scr_dat;
  assign bus.chr_data = chr_dat;

  assign bus.sdram_req  = req;
  assign bus.sdram_addr = req_addr;

  // The client owning the in-flight access is not pending again
  // until its fill lands and the tag compare can be redone.
  assign busy    = state != IDLE;
  assign pend[0] = bus.obj_cs & ~obj_hit
                 & ~(busy & (sel == C_OBJ));
  assign pend[1] = bus.scr_cs & ~scr_hit
                 & ~(busy & (sel == C_SCR));
  assign pend[2] = bus.chr_cs & ~chr_hit
                 & ~(busy & (sel == C_CHR));
  assign gnt_any = |pend;

  // Offsets wrap modulo 2^22
  assign obj_full = {4'd0, bus.obj_addr} + OBJ_OFFSET;
  assign scr_full = {5'd0, bus.scr_addr} + SCR_OFFSET;
  assign chr_full = {7'd0, bus.chr_addr} + CHR_OFFSET;

  // Round-robin: search starts at the client after the last one served
  always_comb begin
    gnt = C_OBJ;
    case (last)
      C_OBJ: begin
        if (pend[1])      gnt = C_SCR;
        else if (pend[2]) gnt = C_CHR;
        else              gnt = C_OBJ;
      end
      C_SCR: begin
        if (pend[2])      gnt = C_CHR;
        else if (pend[0]) gnt = C_OBJ;
        else              gnt = C_SCR;
      end
      default: begin
        if (pend[0])      gnt = C_OBJ;
        else if (pend[1]) gnt = C_SCR;
        else              gnt = C_CHR;
      end
    endcase
  end

  always_comb begin
    state_nx    = state;
    sel_nx      = sel;
    last_nx     = last;
    req_nx      = req;
    req_addr_nx = req_addr;
    req_tag_nx  = req_tag;
    fill        = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          sel_nx   = gnt;
          req_nx   = 1'b1;
          state_nx = WAIT_ACK;
          case (gnt)
            C_OBJ: begin
              req_addr_nx = obj_full;
              req_tag_nx  = bus.obj_addr;
            end
            C_SCR: begin
              req_addr_nx = scr_full;
              req_tag_nx  = {1'b0, bus.scr_addr};
            end
            default: begin
              req_addr_nx = chr_full;
              req_tag_nx  = {3'd0, bus.chr_addr};
            end
          endcase
        end
      end
      WAIT_ACK: begin
        if (bus.sdram_ack) begin
          req_nx = 1'b0;
          // ack and rdy together: accept, then fill at once
          if (bus.sdram_rdy) begin
            fill     = 1'b1;
            last_nx  = sel;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (bus.sdram_rdy) begin
          fill     = 1'b1;
          last_nx  = sel;
          state_nx = IDLE;
        end
      end
      default: begin
        req_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= C_OBJ;
      last     <= C_CHR;
      req      <= 1'b0;
      req_addr <= 22'd0;
      req_tag  <= 18'd0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      last     <= last_nx;
      req      <= req_nx;
      req_addr <= req_addr_nx;
      req_tag  <= req_tag_nx;
    end
  end

  // The fill always uses the tag latched at grant time, so a client
  // that moved on meanwhile sees a mismatch and asks again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obj_tag <= 18'd0;
      scr_tag <= 17'd0;
      chr_tag <= 15'd0;
      obj_dat <= 16'd0;
      scr_dat <= 16'd0;
      chr_dat <= 16'd0;
      obj_vld <= 1'b0;
      scr_vld <= 1'b0;
      chr_vld <= 1'b0;
    end else if (fill) begin
      case (sel)
        C_OBJ: begin
          obj_tag <= req_tag;
          obj_dat <= bus.sdram_data;
          obj_vld <= 1'b1;
        end
        C_SCR: begin
          scr_tag <= req_tag[16:0];
          scr_dat <= bus.sdram_data;
          scr_vld <= 1'b1;
        end
        default: begin
          chr_tag <= req_tag[14:0];
          chr_dat <= bus.sdram_data;
          chr_vld <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
// tb_jtdd_gfx_arb: directed scenarios plus randomized run for jtdd_gfx_arb.
// Acts as layer engines and SDRAM controller; reference model in-bench.
module tb_jtdd_gfx_arb;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  jtdd_gfx_arb_if bus ();

  jtdd_gfx_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.obj_cs     = 1'b0;
    bus.obj_addr   = '0;
    bus.scr_cs     = 1'b0;
    bus.scr_addr   = '0;
    bus.chr_cs     = 1'b0;
    bus.chr_addr   = '0;
    bus.sdram_ack  = 1'b0;
    bus.sdram_rdy  = 1'b0;
    bus.sdram_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], a[9:0]} ^ 16'h5A5A;
  endfunction

  // SDRAM responder: waits for a request, acks after ack_dly cycles,
  // returns rdy rdy_dly cycles after ack (0 = same cycle as ack).
  task automatic serve(input int ack_dly, input int rdy_dly,
                       input logic [15:0] d,
                       output logic [21:0] got, output bit to);
    to  = 1'b1;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.sdram_req === 1'b1) begin
        to = 1'b0;
        break;
      end
      step();
    end
    if (!to) begin
      got = bus.sdram_addr;
      repeat (ack_dly) step();
      bus.sdram_ack = 1'b1;
      if (rdy_dly == 0) begin
        bus.sdram_rdy  = 1'b1;
        bus.sdram_data = d;
      end
      step();
      bus.sdram_ack  = 1'b0;
      bus.sdram_rdy  = 1'b0;
      if (rdy_dly > 0) begin
        repeat (rdy_dly - 1) step();
        bus.sdram_rdy  = 1'b1;
        bus.sdram_data = d;
        step();
        bus.sdram_rdy  = 1'b0;
      end
      #1;
    end
  endtask

  function automatic logic get_ok(input int k);
    case (k)
      0: return bus.obj_ok;
      1: return bus.scr_ok;
      default: return bus.chr_ok;
    endcase
  endfunction

  function automatic logic [15:0] get_data(input int k);
    case (k)
      0: return bus.obj_data;
      1: return bus.scr_data;
      default: return bus.chr_data;
    endcase
  endfunction

  task automatic set_client(input int k, input bit c, input int a);
    case (k)
      0: begin bus.obj_cs = c; bus.obj_addr = 18'(a); end
      1: begin bus.scr_cs = c; bus.scr_addr = 17'(a); end
      default: begin bus.chr_cs = c; bus.chr_addr = 15'(a); end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    bus.obj_cs = 1'b1;
    bus.scr_cs = 1'b1;
    bus.chr_cs = 1'b1;
    #1;
    checks++;
    if ({bus.obj_ok, bus.scr_ok, bus.chr_ok} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ok got=%b exp=000",
               {bus.obj_ok, bus.scr_ok, bus.chr_ok});
    end
    checks++;
    if (bus.sdram_req !== 1'b0 || bus.sdram_addr !== 22'd0) begin
      errors++;
      $display("FAIL reset_sdram got req=%b addr=%h exp 0/0",
               bus.sdram_req, bus.sdram_addr);
    end
    checks++;
    if (bus.obj_data !== 16'd0 || bus.chr_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0", bus.obj_data,
               bus.chr_data);
    end
    idle_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_miss_hit();
    bit ok_all;
    do_reset();
    bus.obj_cs   = 1'b1;
    bus.obj_addr = 18'h00010;
    #1;
    checks++;
    if (bus.obj_ok !== 1'b0) begin
      errors++;
      $display("FAIL miss_ok0 got=%b exp=0", bus.obj_ok);
    end
    step();
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h00010) begin
      errors++;
      $display("FAIL miss_req got req=%b addr=%h exp 1/000010",
               bus.sdram_req, bus.sdram_addr);
    end
    step();
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    #1;
    checks++;
    if (bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL miss_req_drop got=%b exp=0", bus.sdram_req);
    end
    step();
    step();
    bus.sdram_rdy  = 1'b1;
    bus.sdram_data = 16'hA5A5;
    #1;
    checks++;
    if (bus.obj_ok !== 1'b0) begin
      errors++;
      $display("FAIL miss_ok_at_rdy got=%b exp=0", bus.obj_ok);
    end
    step();
    bus.sdram_rdy  = 1'b0;
    bus.sdram_data = 16'h0000;
    #1;
    checks++;
    if (bus.obj_ok !== 1'b1 || bus.obj_data !== 16'hA5A5) begin
      errors++;
      $display("FAIL miss_fill got ok=%b data=%h exp 1/a5a5",
               bus.obj_ok, bus.obj_data);
    end
    ok_all = 1'b1;
    repeat (4) begin
      step();
      if (bus.sdram_req !== 1'b0 || bus.obj_ok !== 1'b1) ok_all = 1'b0;
    end
    checks++;
    if (!ok_all) begin
      errors++;
      $display("FAIL hit_no_req got extra req or lost ok exp none");
    end
    bus.obj_addr = 18'h00011;
    #1;
    checks++;
    if (bus.obj_ok !== 1'b0) begin
      errors++;
      $display("FAIL hit_other_addr got ok=%b exp=0", bus.obj_ok);
    end
    bus.obj_addr = 18'h00010;
    #1;
    checks++;
    if (bus.obj_ok !== 1'b1) begin
      errors++;
      $display("FAIL hit_same_cycle got ok=%b exp=1", bus.obj_ok);
    end
    bus.obj_cs = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [21:0] got;
    bit          to;
    logic [21:0] exp [3] = '{22'h000200, 22'h040300, 22'h060400};
    do_reset();
    bus.obj_cs   = 1'b1;
    bus.obj_addr = 18'h00200;
    bus.scr_cs   = 1'b1;
    bus.scr_addr = 17'h00300;
    bus.chr_cs   = 1'b1;
    bus.chr_addr = 15'h0400;
    for (int i = 0; i < 3; i++) begin
      serve(1, 2, 16'h1000 + 16'(i), got, to);
      checks++;
      if (to || got !== exp[i]) begin
        errors++;
        $display("FAIL rr_grant%0d got=%h timeout=%0b exp=%h",
                 i, got, to, exp[i]);
      end
    end
    checks++;
    if ({bus.obj_ok, bus.scr_ok, bus.chr_ok} !== 3'b111
        || bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL rr_all_ok got ok=%b req=%b exp 111/0",
               {bus.obj_ok, bus.scr_ok, bus.chr_ok}, bus.sdram_req);
    end
    checks++;
    if (bus.obj_data !== 16'h1000 || bus.scr_data !== 16'h1001
        || bus.chr_data !== 16'h1002) begin
      errors++;
      $display("FAIL rr_data got %h %h %h exp 1000 1001 1002",
               bus.obj_data, bus.scr_data, bus.chr_data);
    end
    bus.obj_addr = 18'h00201;
    serve(0, 1, 16'h2001, got, to);
    checks++;
    if (to || got !== 22'h000201) begin
      errors++;
      $display("FAIL rr_obj_again got=%h exp=000201", got);
    end
    bus.obj_addr = 18'h00202;
    bus.scr_addr = 17'h00301;
    serve(0, 1, 16'h2002, got, to);
    checks++;
    if (to || got !== 22'h040301) begin
      errors++;
      $display("FAIL rr_scr_first got=%h exp=040301", got);
    end
    serve(0, 1, 16'h2003, got, to);
    checks++;
    if (to || got !== 22'h000202) begin
      errors++;
      $display("FAIL rr_obj_second got=%h exp=000202", got);
    end
    idle_inputs();
  endtask

  task automatic test_addr_change();
    logic [21:0] got;
    bit          to;
    bus.obj_cs   = 1'b1;
    bus.obj_addr = 18'h00100;
    for (int i = 0; i < 20 && bus.sdram_req !== 1'b1; i++) step();
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h000100) begin
      errors++;
      $display("FAIL chg_req got req=%b addr=%h exp 1/000100",
               bus.sdram_req, bus.sdram_addr);
    end
    step();
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    bus.obj_addr  = 18'h00101;
    step();
    step();
    bus.sdram_rdy  = 1'b1;
    bus.sdram_data = 16'hBEEF;
    step();
    bus.sdram_rdy  = 1'b0;
    #1;
    checks++;
    if (bus.obj_ok !== 1'b0) begin
      errors++;
      $display("FAIL chg_ok_stale got=%b exp=0", bus.obj_ok);
    end
    serve(0, 1, 16'hCAFE, got, to);
    checks++;
    if (to || got !== 22'h000101) begin
      errors++;
      $display("FAIL chg_refetch got=%h exp=000101", got);
    end
    checks++;
    if (bus.obj_ok !== 1'b1 || bus.obj_data !== 16'hCAFE) begin
      errors++;
      $display("FAIL chg_ok got ok=%b data=%h exp 1/cafe",
               bus.obj_ok, bus.obj_data);
    end
    idle_inputs();
  endtask

  task automatic test_ack_rdy_same();
    logic [21:0] got;
    bit          to;
    bus.chr_cs   = 1'b1;
    bus.chr_addr = 15'h0055;
    serve(1, 0, 16'h1234, got, to);
    checks++;
    if (to || got !== 22'h060055) begin
      errors++;
      $display("FAIL same_addr got=%h exp=060055", got);
    end
    checks++;
    if (bus.chr_ok !== 1'b1 || bus.chr_data !== 16'h1234
        || bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL same_fill got ok=%b data=%h req=%b exp 1/1234/0",
               bus.chr_ok, bus.chr_data, bus.sdram_req);
    end
    bus.chr_addr = 15'h0056;
    step();
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h060056) begin
      errors++;
      $display("FAIL same_idle got req=%b addr=%h exp 1/060056",
               bus.sdram_req, bus.sdram_addr);
    end
    serve(0, 1, 16'h5678, got, to);
    checks++;
    if (to || bus.chr_ok !== 1'b1 || bus.chr_data !== 16'h5678) begin
      errors++;
      $display("FAIL same_next got ok=%b data=%h exp 1/5678",
               bus.chr_ok, bus.chr_data);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.chr_cs   = 1'b1;
    bus.chr_addr = 15'h0056;
    bus.scr_cs   = 1'b1;
    bus.scr_addr = 17'h00077;
    for (int i = 0; i < 20 && bus.sdram_req !== 1'b1; i++) step();
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h040077) begin
      errors++;
      $display("FAIL rstmid_req got req=%b addr=%h exp 1/040077",
               bus.sdram_req, bus.sdram_addr);
    end
    step();
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    #1;
    checks++;
    if (bus.chr_ok !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre_ok got=%b exp=1", bus.chr_ok);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.obj_ok, bus.scr_ok, bus.chr_ok} !== 3'b000
        || bus.sdram_req !== 1'b0 || bus.sdram_addr !== 22'd0) begin
      errors++;
      $display("FAIL rstmid_clear got ok=%b req=%b addr=%h exp 000/0/0",
               {bus.obj_ok, bus.scr_ok, bus.chr_ok},
               bus.sdram_req, bus.sdram_addr);
    end
    step();
    rst            = 1'b0;
    bus.scr_cs     = 1'b0;
    bus.chr_cs     = 1'b0;
    bus.sdram_rdy  = 1'b1;
    bus.sdram_data = 16'hDEAD;
    step();
    bus.sdram_rdy = 1'b0;
    bus.scr_cs    = 1'b1;
    bus.chr_cs    = 1'b1;
    #1;
    checks++;
    if (bus.scr_ok !== 1'b0 || bus.scr_data !== 16'd0
        || bus.chr_ok !== 1'b0 || bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_late_rdy got scr=%b/%h chr=%b req=%b exp 0",
               bus.scr_ok, bus.scr_data, bus.chr_ok, bus.sdram_req);
    end
    idle_inputs();
  endtask

  task automatic test_cs_low();
    logic [21:0] got;
    bit          to;
    bit          quiet;
    bus.chr_cs   = 1'b1;
    bus.chr_addr = 15'h0123;
    serve(0, 0, 16'h4242, got, to);
    checks++;
    if (to || got !== 22'h060123 || bus.chr_ok !== 1'b1) begin
      errors++;
      $display("FAIL cs_fill got addr=%h ok=%b exp 060123/1",
               got, bus.chr_ok);
    end
    bus.chr_cs   = 1'b0;
    bus.chr_addr = 15'h0456;
    quiet = 1'b1;
    repeat (5) begin
      step();
      if (bus.sdram_req !== 1'b0 || bus.chr_ok !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL cs_low_req got request or ok while cs low exp none");
    end
    bus.chr_addr = 15'h0123;
    bus.chr_cs   = 1'b1;
    #1;
    checks++;
    if (bus.chr_ok !== 1'b1 || bus.chr_data !== 16'h4242) begin
      errors++;
      $display("FAIL cs_retained got ok=%b data=%h exp 1/4242",
               bus.chr_ok, bus.chr_data);
    end
    idle_inputs();
  endtask

  // Transaction-level model: each client owns a one-word cache;
  // an idle port grants the first missing client after the last one
  // served, and the grant completes when the responder returns data.
  task automatic test_random();
    bit          mv [3];
    int          mtag [3];
    logic [15:0] mdat [3];
    int          off [3] = '{0, 'h40000, 'h60000};
    int          last = 2;
    bit          infl = 1'b0;
    bit          acc = 1'b0;
    bit          mreq = 1'b0;
    int          msel = 0;
    int          mrtag = 0;
    int          cnt = 0;
    logic [21:0] maddr = '0;
    bit          cs [3];
    int          addr [3];
    bit          ack, rdy, found, exp_ok;
    logic [15:0] rdata;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; mtag[k] = 0; mdat[k] = '0;
      cs[k] = 1'b0; addr[k] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) cs[k] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 7) == 0)
          addr[k] = int'($urandom_range(0, 5)) + 8 * k;
        set_client(k, cs[k], addr[k]);
      end
      ack   = 1'b0;
      rdy   = 1'b0;
      rdata = 16'($urandom);
      if (infl && !acc) begin
        if (cnt == 0) begin
          ack = 1'b1;
          rdy = ($urandom_range(0, 3) == 0);
          cnt = $urandom_range(0, 3);
        end else cnt--;
      end else if (infl && acc) begin
        if (cnt == 0) rdy = 1'b1;
        else cnt--;
      end else begin
        rdy = ($urandom_range(0, 7) == 0);
      end
      if (infl && rdy) rdata = mem_word(maddr);
      bus.sdram_ack  = ack;
      bus.sdram_rdy  = rdy;
      bus.sdram_data = rdata;
      #1;
      for (int k = 0; k < 3; k++) begin
        exp_ok = cs[k] && mv[k] && (mtag[k] == addr[k]);
        checks++;
        if (get_ok(k) !== exp_ok || get_data(k) !== mdat[k]) begin
          errors++;
          $display("FAIL rnd_client%0d cyc=%0d got ok=%b data=%h exp %b/%h",
                   k, cyc, get_ok(k), get_data(k), exp_ok, mdat[k]);
        end
      end
      checks++;
      if (bus.sdram_req !== mreq || bus.sdram_addr !== maddr) begin
        errors++;
        $display("FAIL rnd_sdram cyc=%0d got req=%b addr=%h exp %b/%h",
                 cyc, bus.sdram_req, bus.sdram_addr, mreq, maddr);
      end
      if (!infl) begin
        found = 1'b0;
        for (int i = 1; i <= 3; i++) begin
          int k;
          k = (last + i) % 3;
          if (!found && cs[k] && !(mv[k] && mtag[k] == addr[k])) begin
            found = 1'b1;
            infl  = 1'b1;
            acc   = 1'b0;
            msel  = k;
            maddr = 22'(addr[k] + off[k]);
            mrtag = addr[k];
            mreq  = 1'b1;
            cnt   = $urandom_range(0, 3);
          end
        end
      end else if ((!acc && ack && rdy) || (acc && rdy)) begin
        mreq       = 1'b0;
        mv[msel]   = 1'b1;
        mtag[msel] = mrtag;
        mdat[msel] = rdata;
        last       = msel;
        infl       = 1'b0;
      end else if (!acc && ack) begin
        mreq = 1'b0;
        acc  = 1'b1;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_round_robin();
    test_addr_change();
    test_ack_rdy_same();
    test_reset_mid();
    test_cs_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
